cnn_conv3x3: RTL and testbench
==============================

Name: cnn_conv3x3

Overview:
- Downstream compute stage of the CNN peripheral memory. Once the HPS has loaded a 3x3 kernel and an 8-bit image into that memory, a `start` pulse launches this block.
- It reads the kernel and image through the memory's byte read port (registered data, 1-cycle latency).
- It computes a valid-mode 3x3 convolution with arithmetic shift and ReLU/saturation.
- It streams one 8-bit result per output pixel, in row-major order, over a valid/ready interface.

Parameters:
- IMG_W, 16, image width in pixels (>=3)
- IMG_H, 16, image height in pixels (>=3)
- W_BASE, 0, byte address of kernel weight k=0 (k = i*3+j, row-major)
- IMG_BASE, 16, byte address of pixel (0,0); pixel (r,c) is at IMG_BASE + r*IMG_W + c
- ACC_W, 20, signed accumulator width
- SHIFT, 4, arithmetic right shift applied to the accumulator before clamping

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- start  in  1  launch request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last result handshake
- mem_chipselect  out  1  asserted together with mem_read
- mem_read  out  1  read strobe, one byte per cycle
- mem_address  out  32  byte address of the current read
- mem_rdata  in  8  read data, valid the cycle after mem_read
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result when out_valid & out_ready
- out_data  out  8  clamped result
- out_row  out  8  output row index (0..IMG_H-3)
- out_col  out  8  output column index (0..IMG_W-3)

Behaviour:
- Reset (reset==0): FSM goes to IDLE. All outputs are 0: busy, done, mem_read, mem_chipselect, out_valid, mem_address, out_data, out_row, out_col. Weights, accumulator and counters are cleared. Reset takes effect mid-operation with no further reads and no pending result.
- FSM states: IDLE -> LOAD_W -> FETCH -> DRAIN -> SAT -> EMIT -> (FETCH | FIN) -> IDLE.
- IDLE: start==1 moves to LOAD_W and sets busy. A start asserted in any other state is ignored.
- LOAD_W: issue 9 consecutive reads at W_BASE+0..8, one per cycle. Each returning byte is stored as signed weight w[k] one cycle later. The last weight is captured during the first FETCH cycle; the pipeline is overlapped.
- FETCH: for output (r,c), issue 9 consecutive reads at IMG_BASE + (r+i)*IMG_W + (c+j), with k = i*3+j ascending. The accumulator is cleared when the first pixel read is issued. Each returning byte p, zero-extended, adds p*w[k] (signed) into the accumulator.
- DRAIN: one cycle with no read; accumulates the 9th product.
- SAT: computes s = acc >>> SHIFT (arithmetic). out_data = 0 if s<0, 255 if s>255, else s[7:0]. out_row and out_col are loaded.
- EMIT: out_valid=1. out_data, out_row and out_col are held stable while out_ready==0. On handshake:
  - if another pixel remains, advance col (wrap to 0 and increment row at col==IMG_W-3) and go to FETCH;
  - otherwise go to FIN.
- FIN: done=1 for one cycle, busy drops to 0, return to IDLE.
- Per-pixel latency: 9 FETCH + 1 DRAIN + 1 SAT = out_valid at the 12th cycle after FETCH entry with out_ready held high. The next pixel's FETCH starts the cycle after the handshake.
- Reads per run: exactly 9 + 9*(IMG_H-2)*(IMG_W-2); for defaults, 1773. mem_read is never asserted outside LOAD_W and FETCH.
- Width: product is 17-bit signed. With ACC_W=20 the worst case of ±9*255*128 fits, so no accumulator overflow handling is required.
- Memory contents changed by the HPS during a run are not protected; results are undefined in that case.

Test Plan:
- Identity kernel (w[4]=16, others 0), SHIFT=4, image pixel(r,c)=(r*16+c)&0xFF -> 196 results, each out_data = pixel(r+1,c+1). For example (0,0)->17 and (13,13)->238. Row-major order, then a single done pulse.
- All weights 1, all pixels 255 -> acc=2295, out_data=143 for every output; exactly 1773 mem_read cycles counted.
- All weights -1 (0xFF), pixels 200 -> negative accumulator, out_data=0 (ReLU clamp).
- All weights 127, pixels 255 -> 291465>>4=18216, out_data=255 (saturation).
- Backpressure: out_ready=0 for 5 cycles on the first result -> out_valid, out_data, out_row and out_col unchanged and no mem_read during the stall; the result is accepted on out_ready=1. Also pulse start while busy -> ignored, with no restart and no change in read count.
- Pull reset to 0 during FETCH of pixel (3,5) -> the next cycle shows busy=0, mem_read=0, out_valid=0. A subsequent start runs a full correct convolution from (0,0).

Source files
------------

// File: rtl/cnn_conv3x3_if.sv
// rtl/cnn_conv3x3_if.sv - memory read port and result stream bundle for cnn_conv3x3
`timescale 1ns/1ps
interface cnn_conv3x3_if;
    logic        mem_chipselect;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_row;
    logic [7:0]  out_col;

    modport master (
        output mem_chipselect, mem_read, mem_address,
        input  mem_rdata,
        output out_valid, out_data, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  mem_chipselect, mem_read, mem_address,
        output mem_rdata,
        input  out_valid, out_data, out_row, out_col,
        output out_ready
    );
endinterface

// File: rtl/cnn_conv3x3.sv
// rtl/cnn_conv3x3.sv - valid-mode 3x3 convolution reading kernel/image from byte memory, streaming clamped results
`timescale 1ns/1ps
module cnn_conv3x3 #(
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int W_BASE   = 0,
    parameter int IMG_BASE = 16,
    parameter int ACC_W    = 20,
    parameter int SHIFT    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    cnn_conv3x3_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD_W, FETCH, DRAIN, SAT, EMIT, FIN} state_t;

    localparam logic [7:0]  LAST_R   = 8'(IMG_H - 3);
    localparam logic [7:0]  LAST_C   = 8'(IMG_W - 3);
    localparam logic [31:0] ROW_STEP = 32'(IMG_W - 2);
    localparam logic signed [ACC_W-1:0] MAX_S = 255;

    state_t                  state;
    logic [3:0]              k;
    logic [1:0]              j;
    logic [7:0]              r, c;
    logic [31:0]             pix_base;
    logic signed [7:0]       w [9];
    logic                    ld_valid, ld_w;
    logic [3:0]              ld_k;
    logic signed [ACC_W-1:0] acc;

    // Data returning this cycle belongs to the read issued last cycle, tagged by ld_*.
    logic signed [16:0]      pix_ext, w_ext, prod;
    logic signed [ACC_W-1:0] prod_ext, s;
    logic [7:0]              sat_val;

    assign pix_ext  = {9'd0, bus.mem_rdata};
    assign w_ext    = {{9{w[ld_k][7]}}, w[ld_k]};
    assign prod     = pix_ext * w_ext;
    assign prod_ext = {{(ACC_W-17){prod[16]}}, prod};
    assign s        = acc >>> SHIFT;

    always_comb begin
        sat_val = s[7:0];
        if (s[ACC_W-1])
            sat_val = 8'd0;
        else if (s > MAX_S)
            sat_val = 8'd255;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            bus.mem_read       <= 1'b0;
            bus.mem_chipselect <= 1'b0;
            bus.mem_address    <= '0;
            bus.out_valid      <= 1'b0;
            bus.out_data       <= '0;
            bus.out_row        <= '0;
            bus.out_col        <= '0;
            k                  <= '0;
            j                  <= '0;
            r                  <= '0;
            c                  <= '0;
            pix_base           <= '0;
            ld_valid           <= 1'b0;
            ld_w               <= 1'b0;
            ld_k               <= '0;
            acc                <= '0;
            for (int i = 0; i < 9; i++) w[i] <= '0;
        end else begin
            ld_valid <= bus.mem_read;
            ld_w     <= (state == LOAD_W);
            ld_k     <= k;

            if (ld_valid && ld_w)
                w[ld_k] <= bus.mem_rdata;

            if (state == FETCH && k == 4'd0)
                acc <= '0;
            else if (ld_valid && !ld_w)
                acc <= acc + prod_ext;

            case (state)
                IDLE: begin
                    if (start) begin
                        state              <= LOAD_W;
                        busy               <= 1'b1;
                        bus.mem_read       <= 1'b1;
                        bus.mem_chipselect <= 1'b1;
                        bus.mem_address    <= 32'(W_BASE);
                        k                  <= '0;
                        r                  <= '0;
                        c                  <= '0;
                        pix_base           <= 32'(IMG_BASE);
                    end
                end
                LOAD_W: begin
                    if (k == 4'd8) begin
                        state           <= FETCH;
                        bus.mem_address <= pix_base;
                        k               <= '0;
                        j               <= '0;
                    end else begin
                        k               <= k + 4'd1;
                        bus.mem_address <= bus.mem_address + 32'd1;
                    end
                end
                FETCH: begin
                    if (k == 4'd8) begin
                        state              <= DRAIN;
                        bus.mem_read       <= 1'b0;
                        bus.mem_chipselect <= 1'b0;
                    end else begin
                        k <= k + 4'd1;
                        if (j == 2'd2) begin
                            j               <= '0;
                            bus.mem_address <= bus.mem_address + ROW_STEP;
                        end else begin
                            j               <= j + 2'd1;
                            bus.mem_address <= bus.mem_address + 32'd1;
                        end
                    end
                end
                DRAIN: state <= SAT;
                SAT: begin
                    bus.out_data  <= sat_val;
                    bus.out_row   <= r;
                    bus.out_col   <= c;
                    bus.out_valid <= 1'b1;
                    state         <= EMIT;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (r == LAST_R && c == LAST_C) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            // Wrapping to the next row moves the window origin by 3 bytes.
                            if (c == LAST_C) begin
                                c               <= '0;
                                r               <= r + 8'd1;
                                pix_base        <= pix_base + 32'd3;
                                bus.mem_address <= pix_base + 32'd3;
                            end else begin
                                c               <= c + 8'd1;
                                pix_base        <= pix_base + 32'd1;
                                bus.mem_address <= pix_base + 32'd1;
                            end
                            state              <= FETCH;
                            bus.mem_read       <= 1'b1;
                            bus.mem_chipselect <= 1'b1;
                            k                  <= '0;
                            j                  <= '0;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_conv3x3.sv
// tb/tb_cnn_conv3x3.sv - directed bench for cnn_conv3x3 with a registered byte memory model
`timescale 1ns/1ps
module tb_cnn_conv3x3;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done;
    logic rd_clr;
    int   rd_count;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [7:0] mem [0:271];
    logic [7:0] rdata_q;

    cnn_conv3x3_if bus ();

    cnn_conv3x3 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (bus.mem_read && bus.mem_chipselect)
            rdata_q <= (bus.mem_address < 32'd272) ? mem[bus.mem_address[8:0]] : 8'h00;
    end

    always @(posedge clk) begin
        if (rd_clr)
            rd_count <= 0;
        else if (bus.mem_read)
            rd_count <= rd_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0 identity, 1 ones/255, 2 minus-ones/200, 3 127/255
    task automatic load_mem(input int mode);
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        for (int i = 0; i < 9; i++) begin
            case (mode)
                0: mem[i] = (i == 4) ? 8'd16 : 8'd0;
                1: mem[i] = 8'd1;
                2: mem[i] = 8'hFF;
                default: mem[i] = 8'd127;
            endcase
        end
        for (int rr = 0; rr < 16; rr++)
            for (int cc = 0; cc < 16; cc++) begin
                case (mode)
                    0: mem[16 + rr*16 + cc] = 8'((rr*16 + cc) & 255);
                    2: mem[16 + rr*16 + cc] = 8'd200;
                    default: mem[16 + rr*16 + cc] = 8'd255;
                endcase
            end
    endtask

    function automatic logic [31:0] exp_val(input int mode, input int rr, input int cc);
        case (mode)
            0: return 32'(((rr + 1)*16 + (cc + 1)) & 255);
            1: return 32'd143;
            2: return 32'd0;
            default: return 32'd255;
        endcase
    endfunction

    task automatic run_conv(input int mode, input bit stall, input int n_stop);
        int t;
        @(negedge clk); rd_clr = 1'b1;
        @(negedge clk); rd_clr = 1'b0;
        bus.out_ready = stall ? 1'b0 : 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < n_stop; i++) begin
            t = 0;
            while (!bus.out_valid && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!bus.out_valid) begin
                check($sformatf("result_timeout_m%0d_i%0d", mode, i), 32'(bus.out_valid), 32'd1);
                return;
            end
            check($sformatf("data_m%0d_i%0d", mode, i), 32'(bus.out_data), exp_val(mode, i/14, i%14));
            check($sformatf("rowcol_m%0d_i%0d", mode, i), {16'd0, bus.out_row, bus.out_col},
                  32'((i/14)*256 + i%14));
            if (stall && i == 0) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    start = (s == 1);
                    check($sformatf("stall_valid_%0d", s), 32'(bus.out_valid), 32'd1);
                    check($sformatf("stall_data_%0d", s), 32'(bus.out_data), exp_val(mode, 0, 0));
                    check($sformatf("stall_rowcol_%0d", s), {16'd0, bus.out_row, bus.out_col}, 32'd0);
                    check($sformatf("stall_noread_%0d", s), 32'(bus.mem_read), 32'd0);
                end
                start = 1'b0;
                bus.out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (n_stop == 196) begin
            check($sformatf("done_pulse_m%0d", mode), 32'(done), 32'd1);
            check($sformatf("busy_low_m%0d", mode), 32'(busy), 32'd0);
            @(negedge clk);
            check($sformatf("done_single_m%0d", mode), 32'(done), 32'd0);
            check($sformatf("read_count_m%0d", mode), 32'(rd_count), 32'd1773);
            check($sformatf("idle_noread_m%0d", mode), 32'(bus.mem_read), 32'd0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        rd_clr = 1'b1;
        bus.out_ready = 1'b0;
        load_mem(0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_read", 32'(bus.mem_read), 32'd0);
        check("rst_cs", 32'(bus.mem_chipselect), 32'd0);
        check("rst_addr", bus.mem_address, 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_row", 32'(bus.out_row), 32'd0);
        check("rst_col", 32'(bus.out_col), 32'd0);
        reset = 1'b1;
        rd_clr = 1'b0;

        run_conv(0, 1'b0, 196);
        load_mem(1);
        run_conv(1, 1'b1, 196);
        load_mem(2);
        run_conv(2, 1'b0, 196);
        load_mem(3);
        run_conv(3, 1'b0, 196);

        load_mem(0);
        run_conv(0, 1'b0, 47);
        check("fetch_35_read", 32'(bus.mem_read), 32'd1);
        check("fetch_35_addr", bus.mem_address, 32'd69);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_read", 32'(bus.mem_read), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        run_conv(0, 1'b0, 196);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
